qam_symbol_packer: RTL

QAM_SYMBOL_PACKER -- requirements
Module: qam_symbol_packer

---
 rtl/qam_symbol_packer_pkg.sv | 6 +
 rtl/qam_word_outreg.sv | 43 ++++
 rtl/qam_symbol_packer.sv | 63 ++++++
 3 files changed

// File: rtl/qam_symbol_packer_pkg.sv
// qam_symbol_packer_pkg: symbol/word geometry shared by the QAM mapper and packer
package qam_symbol_packer_pkg;
  localparam int QSP_SYMBOL_BITWIDTH = 4;
  localparam int QSP_SYMS_PER_WORD = 8;
  localparam int QSP_WORD_W = QSP_SYMBOL_BITWIDTH * QSP_SYMS_PER_WORD;
endpackage

// File: rtl/qam_word_outreg.sv
// qam_word_outreg: output word register with valid/ready handshake and word counter
// Optional even parity output when QAM_PACK_PARITY_EN is defined.
module qam_word_outreg import qam_symbol_packer_pkg::*; #(
  parameter int W = QSP_WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic [3:0]   load_nsym,
  input  logic         word_ready,
  output logic         out_free,
  output logic         word_valid,
  output logic [W-1:0] word,
  output logic [3:0]   word_nsym,
  output logic [15:0]  word_cnt
`ifdef QAM_PACK_PARITY_EN
  , output logic       word_parity
`endif
);
  assign out_free = !word_valid || word_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_valid <= 1'b0;
      word <= '0;
      word_nsym <= '0;
      word_cnt <= '0;
`ifdef QAM_PACK_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      if (load) begin
        word <= load_word;
        word_nsym <= load_nsym;
`ifdef QAM_PACK_PARITY_EN
        word_parity <= ^load_word;
`endif
      end
      word_valid <= load || (word_valid && !word_ready);
      if (word_valid && word_ready) word_cnt <= word_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/qam_symbol_packer.sv
// qam_symbol_packer: packs mapper symbols LSB-first into words, with flush of partial words
// Define QAM_PACK_PARITY_EN to add the word_parity output.
module qam_symbol_packer import qam_symbol_packer_pkg::*; #(
  parameter int SYMBOL_BITWIDTH = QSP_SYMBOL_BITWIDTH,
  parameter int SYMS_PER_WORD = QSP_SYMS_PER_WORD,
  localparam int W = SYMBOL_BITWIDTH * SYMS_PER_WORD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sym_valid,
  output logic                       sym_ready,
  input  logic [SYMBOL_BITWIDTH-1:0] symbol,
  input  logic                       flush,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [W-1:0]               word,
  output logic [3:0]                 word_nsym,
  output logic [15:0]                word_cnt
`ifdef QAM_PACK_PARITY_EN
  , output logic                     word_parity
`endif
);
  localparam int CW = $clog2(SYMS_PER_WORD + 1);
  logic [W-1:0] acc_data, nxt_data;
  logic [CW-1:0] acc_cnt, nxt_cnt;
  logic flush_pending, accept, flush_eff, out_free, load;
  assign sym_ready = (acc_cnt != CW'(SYMS_PER_WORD)) && !flush_pending;
  // A full accumulator or an executing flush closes the word; it moves out only when the output is free.
  always_comb begin
    accept = sym_valid && sym_ready;
    nxt_data = accept ? acc_data | (W'(symbol) << (SYMBOL_BITWIDTH * int'(acc_cnt))) : acc_data;
    nxt_cnt = acc_cnt + CW'(accept);
    flush_eff = flush || flush_pending;
    load = out_free && (nxt_cnt == CW'(SYMS_PER_WORD) || (flush_eff && nxt_cnt != '0));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data <= '0;
      acc_cnt <= '0;
      flush_pending <= 1'b0;
    end else begin
      acc_data <= load ? '0 : nxt_data;
      acc_cnt <= load ? '0 : nxt_cnt;
      flush_pending <= !out_free && flush_eff;
    end
  end
  qam_word_outreg #(.W(W)) u_out (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_word(nxt_data),
    .load_nsym(4'(nxt_cnt)),
    .word_ready(word_ready),
    .out_free(out_free),
    .word_valid(word_valid),
    .word(word),
    .word_nsym(word_nsym),
    .word_cnt(word_cnt)
`ifdef QAM_PACK_PARITY_EN
    , .word_parity(word_parity)
`endif
  );
endmodule
